// File: rtl/rib_pkg.sv
// rtl/rib_pkg.sv - shared state, error encoding and helpers for the rib_matrix interconnect
package rib_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } rib_state_e;

  localparam int SEL_W = 4;

  typedef enum logic {
    ERR_NONE  = 1'b0,
    ERR_FAULT = 1'b1
  } rib_err_e;

  function automatic int onehot_to_idx(input logic [15:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rib_matrix_arb.sv
// rtl/rib_matrix_arb.sv - one-hot grant for rib_matrix; RIB_RR_ARB_EN selects round-robin among non-fetch masters
module rib_matrix_arb
  import rib_pkg::*;
#(
  parameter int NUM_M   = 4,
  parameter int FETCH_M = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] i_req,
  input  logic             i_lock,
  input  logic [NUM_M-1:0] i_lock_gnt,
  input  logic             i_done,
  output logic [NUM_M-1:0] o_gnt
);

  localparam logic [NUM_M-1:0] FETCH_MASK = NUM_M'(1) << FETCH_M;

  logic [NUM_M-1:0] w_nf;
  logic [NUM_M-1:0] w_pick;

  assign w_nf = i_req & ~FETCH_MASK;

`ifdef RIB_RR_ARB_EN
  localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  logic [PW-1:0]    r_ptr;
  logic [NUM_M-1:0] w_rot;
  logic [NUM_M-1:0] w_rot_pick;
  int               w_win;

  // Rotate the pointer to bit 0, take the lowest requester, then rotate back
  assign w_rot      = NUM_M'({w_nf, w_nf} >> r_ptr);
  assign w_rot_pick = w_rot & (~w_rot + NUM_M'(1));
  assign w_pick     = NUM_M'(({w_rot_pick, w_rot_pick} << r_ptr) >> NUM_M);
  assign w_win      = onehot_to_idx(16'(o_gnt));

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_done) begin
      r_ptr <= (w_win >= NUM_M - 1) ? '0 : PW'(w_win + 1);
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{clk, rst, i_done};
  assign w_pick   = w_nf & (~w_nf + NUM_M'(1));
`endif

  always_comb begin
    o_gnt = '0;
    if (i_lock) begin
      o_gnt = i_lock_gnt;
    end else if (|w_nf) begin
      o_gnt = w_pick;
    end else begin
      o_gnt = i_req & FETCH_MASK;
    end
  end

endmodule

// File: rtl/rib_matrix.sv
// rtl/rib_matrix.sv - N-master x M-slave bus matrix with wait-state lock and timeout; RIB_RR_ARB_EN enables round-robin
module rib_matrix
  import rib_pkg::*;
#(
  parameter int NUM_M   = 4,
  parameter int NUM_S   = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_HI  = 31,
  parameter int FETCH_M = 1,
  parameter int TMO_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_M*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_M*DATA_W-1:0] m_data_i,
  input  logic [NUM_M-1:0]        m_req_i,
  input  logic [NUM_M-1:0]        m_we_i,
  output logic [NUM_M*DATA_W-1:0] m_data_o,
  output logic [NUM_M-1:0]        m_ready_o,
  output logic [NUM_M-1:0]        m_err_o,
  output logic [NUM_S*ADDR_W-1:0] s_addr_o,
  output logic [NUM_S*DATA_W-1:0] s_data_o,
  input  logic [NUM_S*DATA_W-1:0] s_data_i,
  output logic [NUM_S-1:0]        s_we_o,
  output logic [NUM_S-1:0]        s_req_o,
  input  logic [NUM_S-1:0]        s_ready_i,
  output logic                    hold_flag_o
);

  localparam logic [NUM_M-1:0]  FETCH_MASK = NUM_M'(1) << FETCH_M;
  localparam logic [ADDR_W-1:0] SEL_MASK   = ADDR_W'(2**SEL_W - 1) << (SEL_HI - SEL_W + 1);

  rib_state_e        r_state;
  rib_state_e        w_state_nxt;
  logic [NUM_M-1:0]  r_gnt;
  logic [SEL_W-1:0]  r_slv;
  logic [TMO_W-1:0]  r_cnt;

  logic [NUM_M-1:0]  w_gnt;
  logic              w_lock;
  logic              w_req;
  logic              w_we;
  logic              w_mapped;
  logic              w_sready;
  logic              w_tmo;
  logic              w_done;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rdata;
  logic [SEL_W-1:0]  w_slv;
  logic [NUM_S-1:0]  w_soh;

  assign w_lock = (r_state == ST_LOCK);

  rib_matrix_arb #(
    .NUM_M   (NUM_M),
    .FETCH_M (FETCH_M)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (m_req_i),
    .i_lock     (w_lock),
    .i_lock_gnt (r_gnt),
    .i_done     (w_done),
    .o_gnt      (w_gnt)
  );

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      if (w_gnt[k]) begin
        w_addr  = m_addr_i[k*ADDR_W +: ADDR_W];
        w_wdata = m_data_i[k*DATA_W +: DATA_W];
        w_we    = m_we_i[k];
      end
    end
  end

  // Select indices at or above NUM_S shift out of the one-hot, which marks them unmapped
  assign w_req    = |(m_req_i & w_gnt);
  assign w_slv    = w_lock ? r_slv : w_addr[SEL_HI -: SEL_W];
  assign w_soh    = NUM_S'(16'(1) << w_slv);
  assign w_mapped = |w_soh;
  assign w_sready = |(s_ready_i & w_soh);
  assign w_tmo    = w_lock && (r_cnt == '1) && !w_sready;
  assign w_done   = |m_ready_o;

  always_comb begin
    w_rdata = '0;
    for (int s = 0; s < NUM_S; s++) begin
      if (w_soh[s]) w_rdata = s_data_i[s*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_slv   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_lock) begin
        r_cnt <= r_cnt + TMO_W'(1);
      end else begin
        r_gnt <= w_gnt;
        r_slv <= w_slv;
        r_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_req && w_mapped && !w_sready) w_state_nxt = ST_LOCK;
      ST_LOCK: if (!w_req || w_sready || w_tmo) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    m_data_o    = '0;
    m_ready_o   = '0;
    m_err_o     = '0;
    s_addr_o    = '0;
    s_data_o    = '0;
    s_we_o      = '0;
    s_req_o     = '0;
    hold_flag_o = 1'b0;
    if (rst) begin
      hold_flag_o = w_lock || |(m_req_i & ~FETCH_MASK);
      if (w_req) begin
        for (int s = 0; s < NUM_S; s++) begin
          if (w_soh[s] && !w_tmo) begin
            s_req_o[s]                   = 1'b1;
            s_we_o[s]                    = w_we;
            s_addr_o[s*ADDR_W +: ADDR_W] = w_addr & ~SEL_MASK;
            s_data_o[s*DATA_W +: DATA_W] = w_wdata;
          end
        end
        for (int k = 0; k < NUM_M; k++) begin
          if (w_gnt[k]) begin
            if (w_mapped && !w_tmo) m_data_o[k*DATA_W +: DATA_W] = w_rdata;
            m_ready_o[k] = !w_mapped || w_sready || w_tmo;
            m_err_o[k]   = (!w_mapped || w_tmo) ? ERR_FAULT : ERR_NONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_rib_matrix.sv
// tb/tb_rib_matrix.sv - directed vector bench for rib_matrix
module tb_rib_matrix;

  localparam int NUM_M = 4;
  localparam int NUM_S = 8;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TMO_W = 4;

  logic                 clk;
  logic                 rst;
  logic [NUM_M*AW-1:0]  m_addr_i;
  logic [NUM_M*DW-1:0]  m_data_i;
  logic [NUM_M-1:0]     m_req_i;
  logic [NUM_M-1:0]     m_we_i;
  logic [NUM_M*DW-1:0]  m_data_o;
  logic [NUM_M-1:0]     m_ready_o;
  logic [NUM_M-1:0]     m_err_o;
  logic [NUM_S*AW-1:0]  s_addr_o;
  logic [NUM_S*DW-1:0]  s_data_o;
  logic [NUM_S*DW-1:0]  s_data_i;
  logic [NUM_S-1:0]     s_we_o;
  logic [NUM_S-1:0]     s_req_o;
  logic [NUM_S-1:0]     s_ready_i;
  logic                 hold_flag_o;

  rib_matrix #(
    .NUM_M(NUM_M), .NUM_S(NUM_S), .ADDR_W(AW), .DATA_W(DW),
    .SEL_HI(31), .FETCH_M(1), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .rst(rst),
    .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_req_i(m_req_i), .m_we_i(m_we_i),
    .m_data_o(m_data_o), .m_ready_o(m_ready_o), .m_err_o(m_err_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
    .s_we_o(s_we_o), .s_req_o(s_req_o), .s_ready_i(s_ready_i),
    .hold_flag_o(hold_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string            name;
    logic [3:0]       req;
    logic [3:0]       we;
    logic [3:0][31:0] a;
    logic [7:0]       srdy;
    logic [3:0]       e_rdy;
    logic [3:0]       e_err;
    logic [7:0]       e_sreq;
    logic [7:0]       e_swe;
    logic             e_hold;
    logic [31:0]      e_d;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string name, input logic [3:0] req, input logic [3:0] we,
                              input logic [31:0] a3, input logic [31:0] a2, input logic [31:0] a1,
                              input logic [31:0] a0, input logic [7:0] srdy, input logic [3:0] e_rdy,
                              input logic [3:0] e_err, input logic [7:0] e_sreq, input logic [7:0] e_swe,
                              input logic e_hold, input logic [31:0] e_d);
    vec_t v;
    v.name = name; v.req = req; v.we = we;
    v.a[3] = a3; v.a[2] = a2; v.a[1] = a1; v.a[0] = a0;
    v.srdy = srdy; v.e_rdy = e_rdy; v.e_err = e_err; v.e_sreq = e_sreq;
    v.e_swe = e_swe; v.e_hold = e_hold; v.e_d = e_d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_mready"}, 256'(m_ready_o), 256'(0));
    chk({pfx, "_merr"},   256'(m_err_o),   256'(0));
    chk({pfx, "_mdata"},  256'(m_data_o),  256'(0));
    chk({pfx, "_sreq"},   256'(s_req_o),   256'(0));
    chk({pfx, "_swe"},    256'(s_we_o),    256'(0));
    chk({pfx, "_saddr"},  256'(s_addr_o),  256'(0));
    chk({pfx, "_sdata"},  256'(s_data_o),  256'(0));
    chk({pfx, "_hold"},   256'(hold_flag_o), 256'(0));
  endtask

  task automatic clear_inputs();
    m_addr_i = '0; m_data_i = '0; m_req_i = '0; m_we_i = '0; s_ready_i = '1;
  endtask

  task automatic set_m(input int k, input logic we, input logic [31:0] addr, input logic [31:0] data);
    m_req_i[k] = 1'b1;
    m_we_i[k]  = we;
    m_addr_i[k*AW +: AW] = addr;
    m_data_i[k*DW +: DW] = data;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    next_cycle();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [NUM_M*DW-1:0] em;
    logic [3:0]          rr_exp [3];
    int                  rdy_count;

    for (int s = 0; s < NUM_S; s++) s_data_i[s*DW +: DW] = 32'hD0D0_0000 | 32'(s);
    rst = 1'b0;
    clear_inputs();
    set_m(0, 1'b1, 32'h1000_0004, 32'h5555_0000);
    set_m(2, 1'b0, 32'h7000_0000, 32'h0);
    next_cycle();
    #3;
    chk_all_zero("reset");

    //            name                 req    we     a3            a2            a1            a0            srdy   rdy    err    sreq   swe    hold  data
    vq.push_back(mk("zw_read_s1",      4'h1, 4'h0, 32'h0,        32'h0,        32'h0,        32'h1000_0004, 8'hFF, 4'h1, 4'h0, 8'h02, 8'h00, 1'b1, 32'hD0D0_0001));
    vq.push_back(mk("fetch_only",      4'h2, 4'h0, 32'h0,        32'h0,        32'h0000_0100, 32'h0,        8'hFF, 4'h2, 4'h0, 8'h01, 8'h00, 1'b0, 32'hD0D0_0000));
    vq.push_back(mk("prio_m0",         4'h7, 4'h1, 32'h0,        32'h3000_0000, 32'h0,        32'h2000_0000, 8'hFF, 4'h1, 4'h0, 8'h04, 8'h04, 1'b1, 32'hD0D0_0002));
    vq.push_back(mk("prio_m2_fetch",   4'h6, 4'h0, 32'h0,        32'h3000_0008, 32'h0,        32'h0,        8'hFF, 4'h4, 4'h0, 8'h08, 8'h00, 1'b1, 32'hD0D0_0003));
    vq.push_back(mk("prio_m3_write",   4'hA, 4'h8, 32'h7000_0000, 32'h0,       32'h0,        32'h0,        8'hFF, 4'h8, 4'h0, 8'h80, 8'h80, 1'b1, 32'hD0D0_0007));
    vq.push_back(mk("unmapped_F",      4'h1, 4'h0, 32'h0,        32'h0,        32'h0,        32'hF000_0000, 8'hFF, 4'h1, 4'h1, 8'h00, 8'h00, 1'b1, 32'h0));
    vq.push_back(mk("unmapped_8",      4'h2, 4'h0, 32'h0,        32'h0,        32'h8000_0000, 32'h0,        8'hFF, 4'h2, 4'h2, 8'h00, 8'h00, 1'b0, 32'h0));
    vq.push_back(mk("unmapped_wr",     4'h1, 4'h1, 32'h0,        32'h0,        32'h0,        32'hC000_0010, 8'hFF, 4'h1, 4'h1, 8'h00, 8'h00, 1'b1, 32'h0));
    vq.push_back(mk("slave7_edge",     4'h4, 4'h0, 32'h0,        32'h7FFF_FFFC, 32'h0,        32'h0,        8'hFF, 4'h4, 4'h0, 8'h80, 8'h00, 1'b1, 32'hD0D0_0007));
    vq.push_back(mk("idle",            4'h0, 4'h0, 32'h0,        32'h0,        32'h0,        32'h0,        8'hFF, 4'h0, 4'h0, 8'h00, 8'h00, 1'b0, 32'h0));

    foreach (vq[i]) begin
      do_reset();
      clear_inputs();
      for (int k = 0; k < NUM_M; k++) begin
        if (vq[i].req[k]) set_m(k, vq[i].we[k], vq[i].a[k], 32'hA000_0000 | 32'(k));
      end
      s_ready_i = vq[i].srdy;
      #3;
      em = '0;
      for (int k = 0; k < NUM_M; k++) if (vq[i].e_rdy[k]) em[k*DW +: DW] = vq[i].e_d;
      chk({vq[i].name, "_rdy"},  256'(m_ready_o),   256'(vq[i].e_rdy));
      chk({vq[i].name, "_err"},  256'(m_err_o),     256'(vq[i].e_err));
      chk({vq[i].name, "_sreq"}, 256'(s_req_o),     256'(vq[i].e_sreq));
      chk({vq[i].name, "_swe"},  256'(s_we_o),      256'(vq[i].e_swe));
      chk({vq[i].name, "_hold"}, 256'(hold_flag_o), 256'(vq[i].e_hold));
      chk({vq[i].name, "_data"}, 256'(m_data_o),    256'(em));
    end

    // m0, m2 and the fetch master served in that order as each drops its request
    do_reset();
    clear_inputs();
    set_m(0, 1'b0, 32'h1000_0000, 32'h0);
    set_m(1, 1'b0, 32'h0000_0000, 32'h0);
    set_m(2, 1'b0, 32'h2000_0000, 32'h0);
    #3; chk("prio_seq_m0", 256'(m_ready_o), 256'(4'h1));
    next_cycle(); m_req_i[0] = 1'b0;
    #3; chk("prio_seq_m2", 256'(m_ready_o), 256'(4'h4));
    next_cycle(); m_req_i[2] = 1'b0;
    #3; chk("prio_seq_m1", 256'(m_ready_o), 256'(4'h2));

    // Repeated m0+m2 requests
`ifdef RIB_RR_ARB_EN
    rr_exp[0] = 4'h1; rr_exp[1] = 4'h4; rr_exp[2] = 4'h1;
`else
    rr_exp[0] = 4'h1; rr_exp[1] = 4'h1; rr_exp[2] = 4'h1;
`endif
    do_reset();
    clear_inputs();
    set_m(0, 1'b0, 32'h1000_0000, 32'h0);
    set_m(2, 1'b0, 32'h2000_0000, 32'h0);
    for (int c = 0; c < 3; c++) begin
      #3; chk($sformatf("repeat_grant_%0d", c), 256'(m_ready_o), 256'(rr_exp[c]));
      next_cycle();
    end

    // Wait-state write to slave 7, ready arrives five cycles after the request
    do_reset();
    clear_inputs();
    s_ready_i = 8'h7F;
    set_m(0, 1'b1, 32'h7000_0010, 32'hCAFE_0001);
    #3;
    chk("ws_c0_rdy",   256'(m_ready_o), 256'(0));
    chk("ws_c0_sreq",  256'(s_req_o),   256'(8'h80));
    chk("ws_c0_swe",   256'(s_we_o),    256'(8'h80));
    chk("ws_c0_saddr", 256'(s_addr_o[7*AW +: AW]), 256'(32'h0000_0010));
    chk("ws_c0_sdata", 256'(s_data_o[7*DW +: DW]), 256'(32'hCAFE_0001));
    chk("ws_c0_hold",  256'(hold_flag_o), 256'(1));
    next_cycle();
    set_m(2, 1'b0, 32'h3000_0000, 32'h0);
    rdy_count = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 5) s_ready_i[7] = 1'b1;
      #3;
      if (m_ready_o[0]) rdy_count++;
      if (c < 5) begin
        chk($sformatf("ws_lock%0d_rdy", c),  256'(m_ready_o), 256'(0));
        chk($sformatf("ws_lock%0d_sreq", c), 256'(s_req_o),   256'(8'h80));
        chk($sformatf("ws_lock%0d_swe", c),  256'(s_we_o),    256'(8'h80));
      end else begin
        chk("ws_done_rdy",  256'(m_ready_o), 256'(4'h1));
        chk("ws_done_err",  256'(m_err_o),   256'(0));
        chk("ws_done_data", 256'(m_data_o),  256'(32'hD0D0_0007));
      end
      next_cycle();
    end
    m_req_i[0] = 1'b0;
    #3;
    chk("ws_single_pulse", 256'(rdy_count), 256'(1));
    chk("b2b_m2_rdy",      256'(m_ready_o), 256'(4'h4));
    chk("b2b_m2_sreq",     256'(s_req_o),   256'(8'h08));

    // Timeout with TMO_W=4: error exactly 16 cycles after the request cycle
    do_reset();
    clear_inputs();
    s_ready_i = '0;
    set_m(1, 1'b0, 32'h5000_0000, 32'h0);
    for (int c = 0; c <= 16; c++) begin
      #3;
      if (c == 0) chk("tmo_hold_idle", 256'(hold_flag_o), 256'(0));
      if (c == 1) chk("tmo_hold_lock", 256'(hold_flag_o), 256'(1));
      if (c < 16) begin
        chk($sformatf("tmo_wait%0d_rdy", c), 256'(m_ready_o), 256'(0));
      end else begin
        chk("tmo_rdy",  256'(m_ready_o), 256'(4'h2));
        chk("tmo_err",  256'(m_err_o),   256'(4'h2));
        chk("tmo_data", 256'(m_data_o),  256'(0));
        chk("tmo_sreq", 256'(s_req_o),   256'(0));
      end
      next_cycle();
    end
    #3;
    chk("tmo_idle_rdy",  256'(m_ready_o),   256'(0));
    chk("tmo_idle_sreq", 256'(s_req_o),     256'(8'h20));
    chk("tmo_idle_hold", 256'(hold_flag_o), 256'(0));
    next_cycle();

    // Abandon: locked master drops its request
    m_req_i[1] = 1'b0;
    #3;
    chk("abandon_rdy",  256'(m_ready_o),   256'(0));
    chk("abandon_hold", 256'(hold_flag_o), 256'(1));
    next_cycle();
    #3;
    chk("abandon_idle_hold", 256'(hold_flag_o), 256'(0));

    // Reset on the third LOCK cycle
    do_reset();
    clear_inputs();
    s_ready_i = 8'h7F;
    set_m(0, 1'b1, 32'h7000_0000, 32'h0000_1234);
    next_cycle();
    #3; chk("rl_lock1_rdy", 256'(m_ready_o), 256'(0));
    next_cycle();
    #3; chk("rl_lock2_rdy", 256'(m_ready_o), 256'(0));
    next_cycle();
    rst = 1'b0;
    set_m(2, 1'b0, 32'h3000_0000, 32'h0);
    #3;
    chk_all_zero("rst_lock");
    next_cycle();
    rst = 1'b1;
    m_req_i[0] = 1'b0;
    #3;
    chk("rst_then_idle_rdy", 256'(m_ready_o), 256'(4'h4));
    chk("rst_then_idle_err", 256'(m_err_o),   256'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rib_matrix.md
# rib_matrix

Parametrised successor to the fixed 4-master/8-slave RIB interconnect: an N-master × M-slave bus matrix with address-decoded slave select and per-master ready/error handshake. It adds a transaction lock for multi-cycle slaves (I2C-style ready) and a timeout that returns an error instead of hanging. It sits between the cores, the JTAG and UART debug masters and all SoC peripherals in tinyriscv_soc_top. It drives hold_flag_o to stall the fetch path whenever another master owns the bus.

## Interface
- NUM_M, 4, number of masters (2..8)
- NUM_S, 8, number of slaves (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SEL_HI, 31, MSB of the 4-bit slave-select field `addr[SEL_HI:SEL_HI-3]`
- FETCH_M, 1, index of the instruction-fetch master (lowest priority)
- TMO_W, 8, timeout counter width; timeout = 2^TMO_W−1 cycles
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-low reset
- m_addr_i  in  NUM_M*ADDR_W  master addresses, master k at slice k
- m_data_i  in  NUM_M*DATA_W  master write data
- m_req_i  in  NUM_M  request
- m_we_i  in  NUM_M  write enable
- m_data_o  out  NUM_M*DATA_W  read data; valid only to the granted master, 0 to all others
- m_ready_o  out  NUM_M  transfer complete; one bit per master
- m_err_o  out  NUM_M  completion with error (unmapped or timeout); coincides with m_ready_o
- s_addr_o  out  NUM_S*ADDR_W  slave address; the full address is passed, select field zeroed
- s_data_o  out  NUM_S*DATA_W  slave write data
- s_data_i  in  NUM_S*DATA_W  slave read data
- s_we_o  out  NUM_S  slave write enable; only the selected slave is ever high
- s_req_o  out  NUM_S  slave request; only the selected slave is ever high
- s_ready_i  in  NUM_S  slave ready; tie zero-wait slaves to 1
- hold_flag_o  out  1  stall request to the cores

## Operation
- FSM states: IDLE, LOCK.
- **IDLE**
  - Arbitration is combinational over m_req_i. Fixed priority: lowest index wins, except FETCH_M, which always ranks last.
  - The slave index is taken from the address select field.
  - If the index ≥ NUM_S (unmapped), the granted master gets m_ready_o=1, m_err_o=1 and m_data_o=0 in the same cycle. No slave strobe is driven.
  - For a mapped slave, s_req_o, s_we_o, s_addr_o and s_data_o are driven. If s_ready_i=1, m_ready_o=1 in the same cycle and the FSM stays in IDLE (zero-wait).
  - If s_ready_i=0, the grant and slave index are registered and the FSM goes to LOCK.
- **LOCK**
  - Grant and slave are frozen; other requests are ignored.
  - The slave strobes stay driven from the locked master's current inputs.
  - The timeout counter increments each cycle from 0.
  - On s_ready_i=1: m_ready_o=1 and return to IDLE.
  - On counter = 2^TMO_W−1 without ready: m_ready_o=1, m_err_o=1, m_data_o=0, s_req_o is dropped, and return to IDLE.
  - If the locked master drops m_req_i, the transfer is abandoned: the FSM returns to IDLE the next cycle with no ready.
- **hold_flag_o** = 1 when any master other than FETCH_M requests, or when the FSM is in LOCK.
- **Reset**
  - All outputs are 0.
  - FSM goes to IDLE, counter to 0, round-robin pointer to 0.
  - A reset asserted during LOCK aborts the transfer; no ready is issued.

## Timing
- Zero-wait slave: request to m_ready_o takes 0 cycles (combinational).
- Wait-state slave: m_ready_o is asserted in the cycle s_ready_i rises. Minimum total is 1 cycle after entry to LOCK.
- Timeout: error completes exactly 2^TMO_W cycles after the first request cycle.
- Back-to-back: a new grant can be issued in the cycle after a LOCK completion. The IDLE path has no dead cycle.
- Simultaneous requests with ready=1: only the winner sees m_ready_o. Losers wait with m_ready_o=0.

## Configuration
- Macro: RIB_RR_ARB_EN.
- **Defined:** non-fetch masters arbitrate round-robin. The pointer advances to the master after the winner on every completion (ready or error). FETCH_M is still last.
- **Undefined:** fixed priority as described in Operation; no pointer register.

## Structure
- rib_pkg holds:
  - FSM state enum (IDLE/LOCK)
  - select field width constant (4)
  - m_err encoding
  - helper function for one-hot to index
- rib_matrix_arb is the sub-module: the request vector plus lock state in, one-hot grant out. It contains the optional round-robin pointer.
- Top level contains the decode, muxing, FSM and timeout counter.

## Test plan
- **Zero-wait read:** m0 reads 0x1000_0004 from slave1 with s_ready=1 → m_ready_o[0]=1 in the same cycle, m_data_o[0]=s1 data, hold_flag_o=1.
- **Priority:** m0, m2 and FETCH_M request together → m0 granted first, then m2, then m1. With RIB_RR_ARB_EN and repeated m0+m2 requests → grants alternate m0, m2, m0.
- **Wait-state slave:** m0 writes slave7, s_ready_i[7] rises after 5 cycles → LOCK held 5 cycles, m2 request is ignored, m_ready_o[0] pulses once, s_we_o[7] held high throughout.
- **Timeout:** TMO_W=4, slave never ready → m_ready_o=m_err_o=1 on cycle 16, m_data_o=0, back to IDLE.
- **Unmapped:** address 0xF000_0000 with NUM_S=8 → immediate m_err_o=1, m_ready_o=1, all s_req_o=0.
- **Reset mid-LOCK:** rst=0 on cycle 3 of LOCK → next cycle all outputs 0 and FSM in IDLE; no ready issued.
